iterative_right_shifter: RTL and testbench
==========================================

// Module: iterative_right_shifter
// PURPOSE
//  Sequential right shifter: z = x >> d (logical) or x >>> d (arithmetic), with a sticky bit
//  (OR of all discarded bits) for FP mantissa alignment/normalisation in the arithmetic units.
//  Resolves one bit of d per cycle (stage k shifts by 2^k), so area is O(N), not O(N log N).
//  Valid/ready handshake on input and output; one operation in flight.
// PARAMETERS
//  N        32         data width, N >= 2 (non-power-of-2 allowed)
//  D_WIDTH  $clog2(N)  shift-distance width; derived, never overridden
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operands valid
//  in_ready   out  1        block can accept operands (IDLE only)
//  x          in   N        value to shift
//  d          in   D_WIDTH  shift distance, 0 .. 2^D_WIDTH-1 (may exceed N-1)
//  arith      in   1        1: fill with x[N-1]; 0: fill with 0
//  out_valid  out  1        z/sticky valid
//  out_ready  in   1        consumer accepts result
//  z          out  N        shifted result
//  sticky     out  1        OR of x bits shifted out: x[min(d,N)-1:0], 0 when d==0
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, z=0, sticky=0, step counter=0. in_ready=0 while rst=1;
//    1 from the first cycle after rst deasserts.
//  - Reset mid-operation aborts: no result emitted, operand discarded.
//  - FSM: IDLE -> SHIFT -> DONE -> IDLE. in_ready = (state==IDLE) & ~rst.
//  - IDLE: on in_valid & in_ready, register x, d, arith; clear sticky and k=0; go to SHIFT.
//  - SHIFT: exactly D_WIDTH cycles, k = 0..D_WIDTH-1. If d[k]: shift the working register
//    right by 2^k, fill = arith ? sign bit captured at accept : 0;
//    sticky |= OR of the bits shifted out. If 2^k >= N: whole register becomes fill,
//    and sticky |= OR of the whole register. If !d[k]: no change.
//    After k==D_WIDTH-1 go to DONE.
//  - Fixed latency, independent of d: out_valid rises D_WIDTH+1 edges after the accepting edge
//    (N=32: 6). Throughput is one operation per D_WIDTH+2 cycles minimum.
//  - DONE: out_valid=1; z and sticky held stable until out_valid & out_ready; then IDLE.
//    No new operand is accepted in the same cycle as the output handshake.
//  - z and sticky hold their last value after the handshake; they are meaningful only
//    while out_valid=1.
//  - in_valid, x, d, arith are ignored outside IDLE; operand changes during SHIFT/DONE
//    have no effect.
//  - d >= N: z = all fill bits; sticky = |x.
//  - d == 0: z = x, sticky = 0, full latency still applies.
// TESTING
//  1. N=32, x=0x8000_0001, d=4, arith=0 -> z=0x0800_0000, sticky=1;
//     out_valid exactly 6 cycles after accept.
//  2. N=32, x=0x8000_0000, d=31, arith=1 -> z=0xFFFF_FFFF, sticky=0;
//     same operand with arith=0 -> z=0x0000_0001.
//  3. N=32, x=0xDEAD_BEEF, d=0 -> z=0xDEAD_BEEF, sticky=0, latency 6.
//  4. Hold out_ready=0 for 10 cycles in DONE -> out_valid, z and sticky stable, in_ready=0;
//     raise out_ready -> next cycle IDLE, in_ready=1; next operand accepted.
//  5. Assert rst for 1 cycle during SHIFT (k=2) -> out_valid never rises for that operand,
//     z=0, in_ready=1 on the cycle after rst drops.
//  6. N=24 (D_WIDTH=5), x=0x80_0001, d=30: arith=0 -> z=0, sticky=1;
//     arith=1 -> z=0xFF_FFFF, sticky=1.
//     Then 10k random operands with random valid/ready stalls vs behavioural >>/>>> model.

Source files
------------

// File: rtl/iterative_right_shifter_if.sv
// Operand/result handshake bundle for the iterative right shifter.
// The producer drives operands and out_ready; the shifter drives the rest.
interface iterative_right_shifter_if #(
   parameter int N = 32
);
   localparam int D_WIDTH = $clog2(N);

   logic               in_valid;
   logic               in_ready;
   logic [N-1:0]       x;
   logic [D_WIDTH-1:0] d;
   logic               arith;
   logic               out_valid;
   logic               out_ready;
   logic [N-1:0]       z;
   logic               sticky;

   modport master (
      output in_valid, x, d, arith, out_ready,
      input  in_ready, out_valid, z, sticky
   );

   modport slave (
      input  in_valid, x, d, arith, out_ready,
      output in_ready, out_valid, z, sticky
   );
endinterface

// File: rtl/iterative_right_shifter.sv
// Sequential logical/arithmetic right shifter with sticky bit.
// One bit of the distance is resolved per cycle (stage k shifts by 2^k).
module iterative_right_shifter #(
   parameter int N = 32
) (
   input logic                      clk,
   input logic                      rst,
   iterative_right_shifter_if.slave io
);
   localparam int D_WIDTH = $clog2(N);
   localparam int KL = D_WIDTH - 1;
   localparam logic [D_WIDTH-1:0] K_LAST = KL[D_WIDTH-1:0];

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [N-1:0]       w;
   logic [D_WIDTH-1:0] dq;
   logic [D_WIDTH-1:0] k;
   logic               fill;
   logic               stk;
   logic               accept;

   logic [31:0]        amt;
   logic [N-1:0]       ones;
   logic [N-1:0]       fillv;
   logic [N-1:0]       shifted;
   logic               lost;

   assign accept       = io.in_valid && io.in_ready;
   assign io.in_ready  = (state == IDLE) && !rst;
   assign io.out_valid = (state == DONE);
   assign io.z         = w;
   assign io.sticky    = stk;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = SHIFT;
         SHIFT:   if (k == K_LAST) state_nx = DONE;
         DONE:    if (io.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // One stage: shift by 2^k; a stride >= N floods the word with fill.
   always_comb begin
      amt   = 32'd1 << k;
      ones  = '1;
      fillv = {N{fill}};
      if (amt >= N) begin
         shifted = fillv;
         lost    = |w;
      end else begin
         shifted = (w >> amt) | (fillv << (N - amt));
         lost    = |(w & ~(ones << amt));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w    <= '0;
         dq   <= '0;
         k    <= '0;
         fill <= 1'b0;
         stk  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  w    <= io.x;
                  dq   <= io.d;
                  fill <= io.arith & io.x[N-1];
                  stk  <= 1'b0;
                  k    <= '0;
               end
            end
            SHIFT: begin
               if (dq[k]) begin
                  w   <= shifted;
                  stk <= stk | lost;
               end
               k <= (k == K_LAST) ? '0 : k + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_iterative_right_shifter.sv
// Randomised and directed bench for iterative_right_shifter (N=32 and N=24).
// Results are compared against a plain >> / >>> arithmetic model.
module tb_iterative_right_shifter;
   localparam int LAT = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   iterative_right_shifter_if #(.N(32)) i32 ();
   iterative_right_shifter_if #(.N(24)) i24 ();

   iterative_right_shifter #(.N(32)) u32 (
      .clk (clk),
      .rst (rst),
      .io  (i32.slave)
   );

   iterative_right_shifter #(.N(24)) u24 (
      .clk (clk),
      .rst (rst),
      .io  (i24.slave)
   );

   typedef struct {
      bit          s24;
      logic [31:0] x;
      logic [4:0]  d;
      bit          a;
      logic [31:0] ez;
      bit          es;
   } vec_t;

   vec_t dir [6] = '{
      '{1'b0, 32'h8000_0001, 5'd4,  1'b0, 32'h0800_0000, 1'b1},
      '{1'b0, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0},
      '{1'b0, 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 1'b0},
      '{1'b0, 32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, 1'b0},
      '{1'b1, 32'h0080_0001, 5'd30, 1'b0, 32'h0000_0000, 1'b1},
      '{1'b1, 32'h0080_0001, 5'd30, 1'b1, 32'h00FF_FFFF, 1'b1}
   };

   // Reference: sign-extend into 64 bits and use the language's shifts.
   function automatic void model(input int n, input logic [31:0] xv,
                                 input int dv, input bit av,
                                 output logic [31:0] ze, output bit se);
      longint mask;
      longint xs;
      longint xm;
      mask = (longint'(1) << n) - 1;
      xm   = longint'(xv) & mask;
      xs   = xm;
      if (av && xv[n-1]) xs = xs | ~mask;
      if (dv >= n) begin
         ze = (av && xv[n-1]) ? mask[31:0] : 32'h0;
         se = (xm != 0);
      end else begin
         xs = (xs >>> dv) & mask;
         ze = xs[31:0];
         se = ((xm & ((longint'(1) << dv) - 1)) != 0);
      end
   endfunction

   function automatic bit rd_ir(input bit s24);
      return s24 ? i24.in_ready : i32.in_ready;
   endfunction

   function automatic bit rd_ov(input bit s24);
      return s24 ? i24.out_valid : i32.out_valid;
   endfunction

   function automatic logic [31:0] rd_z(input bit s24);
      return s24 ? {8'h00, i24.z} : i32.z;
   endfunction

   function automatic bit rd_st(input bit s24);
      return s24 ? i24.sticky : i32.sticky;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit s24, input bit v, input logic [31:0] xv,
                        input logic [4:0] dv, input bit av);
      if (s24) begin
         i24.in_valid = v;
         i24.x        = xv[23:0];
         i24.d        = dv;
         i24.arith    = av;
      end else begin
         i32.in_valid = v;
         i32.x        = xv;
         i32.d        = dv;
         i32.arith    = av;
      end
   endtask

   task automatic set_ordy(input bit s24, input bit r);
      if (s24) i24.out_ready = r;
      else     i32.out_ready = r;
   endtask

   // lat counts edges from the accepting edge (inclusive) to out_valid.
   task automatic xfer(input bit s24, input logic [31:0] xv,
                       input logic [4:0] dv, input bit av,
                       input int pre, input int stall, input bit scr,
                       output logic [31:0] zv, output bit sv,
                       output int lat, output bit held);
      int n;
      zv   = '0;
      sv   = 1'b0;
      lat  = 0;
      held = 1'b1;
      set_ordy(s24, 1'b0);
      drive(s24, 1'b0, xv, dv, av);
      repeat (pre) tick();
      drive(s24, 1'b1, xv, dv, av);
      n = 0;
      while (!rd_ir(s24) && n < 50) begin
         tick();
         n++;
      end
      if (!rd_ir(s24)) begin
         drive(s24, 1'b0, xv, dv, av);
         return;
      end
      tick();
      lat = 1;
      drive(s24, 1'b0, xv, dv, av);
      while (!rd_ov(s24) && lat < 40) begin
         if (scr)
            drive(s24, 1'($urandom), $urandom, 5'($urandom), 1'($urandom));
         tick();
         lat++;
      end
      if (!rd_ov(s24)) return;
      zv = rd_z(s24);
      sv = rd_st(s24);
      repeat (stall) begin
         if (scr)
            drive(s24, 1'($urandom), $urandom, 5'($urandom), 1'($urandom));
         tick();
         if (!rd_ov(s24) || rd_ir(s24) || rd_z(s24) !== zv
             || rd_st(s24) !== sv)
            held = 1'b0;
      end
      set_ordy(s24, 1'b1);
      tick();
      set_ordy(s24, 1'b0);
      drive(s24, 1'b0, xv, dv, av);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_vec++;
      if (i32.in_ready !== 1'b0 || i24.in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b/%b want 0/0",
                  i32.in_ready, i24.in_ready);
      end
      n_vec++;
      if (i32.out_valid !== 1'b0 || i32.z !== 32'h0 || i32.sticky !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out32: got v=%b z=%h s=%b want 0/0/0",
                  i32.out_valid, i32.z, i32.sticky);
      end
      n_vec++;
      if (i24.out_valid !== 1'b0 || i24.z !== 24'h0 || i24.sticky !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out24: got v=%b z=%h s=%b want 0/0/0",
                  i24.out_valid, i24.z, i24.sticky);
      end
      rst = 1'b0;
      tick();
      n_vec++;
      if (i32.in_ready !== 1'b1 || i24.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL post_reset_ready: got %b/%b want 1/1",
                  i32.in_ready, i24.in_ready);
      end
   endtask

   task automatic test_directed();
      logic [31:0] zv;
      bit          sv;
      bit          held;
      int          lat;
      foreach (dir[i]) begin
         xfer(dir[i].s24, dir[i].x, dir[i].d, dir[i].a, 0, 0, 1'b0,
              zv, sv, lat, held);
         n_vec++;
         if (zv !== dir[i].ez) begin
            n_err++;
            $display("FAIL dir%0d_z: got %h want %h", i, zv, dir[i].ez);
         end
         n_vec++;
         if (sv !== dir[i].es) begin
            n_err++;
            $display("FAIL dir%0d_sticky: got %b want %b", i, sv, dir[i].es);
         end
         n_vec++;
         if (lat !== LAT) begin
            n_err++;
            $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] xv;
      logic [4:0]  dv;
      bit          av;
      logic [31:0] zv;
      logic [31:0] ze;
      bit          sv;
      bit          se;
      bit          held;
      int          lat;
      xv = 32'hC3A5_0F96;
      dv = 5'd13;
      av = 1'b1;
      xfer(1'b0, xv, dv, av, 0, 10, 1'b1, zv, sv, lat, held);
      model(32, xv, int'(dv), av, ze, se);
      n_vec++;
      if (held !== 1'b1) begin
         n_err++;
         $display("FAIL bp_hold: got held=%b want 1", held);
      end
      n_vec++;
      if (zv !== ze || sv !== se) begin
         n_err++;
         $display("FAIL bp_result: got %h/%b want %h/%b", zv, sv, ze, se);
      end
      n_vec++;
      if (i32.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_ready_after: got %b want 1", i32.in_ready);
      end
      xv = 32'h1234_5678;
      dv = 5'd7;
      av = 1'b0;
      xfer(1'b0, xv, dv, av, 0, 0, 1'b0, zv, sv, lat, held);
      model(32, xv, int'(dv), av, ze, se);
      n_vec++;
      if (zv !== ze || sv !== se || lat !== LAT) begin
         n_err++;
         $display("FAIL bp_next: got %h/%b/%0d want %h/%b/%0d",
                  zv, sv, lat, ze, se, LAT);
      end
   endtask

   task automatic test_reset_abort();
      bit rose;
      drive(1'b0, 1'b1, 32'hFFFF_0000, 5'd9, 1'b1);
      tick();
      drive(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      n_vec++;
      if (i32.out_valid !== 1'b0 || i32.z !== 32'h0 || i32.in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL abort_reset: got v=%b z=%h rdy=%b want 0/0/0",
                  i32.out_valid, i32.z, i32.in_ready);
      end
      rst = 1'b0;
      #1;
      n_vec++;
      if (i32.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL abort_ready: got %b want 1", i32.in_ready);
      end
      rose = 1'b0;
      repeat (12) begin
         tick();
         if (i32.out_valid !== 1'b0) rose = 1'b1;
      end
      n_vec++;
      if (rose !== 1'b0) begin
         n_err++;
         $display("FAIL abort_no_output: got out_valid rise=%b want 0", rose);
      end
   endtask

   task automatic test_random();
      logic [31:0] xv;
      logic [4:0]  dv;
      bit          av;
      bit          s24;
      logic [31:0] zv;
      logic [31:0] ze;
      bit          sv;
      bit          se;
      bit          held;
      int          lat;
      for (int i = 0; i < 3000; i++) begin
         s24 = 1'($urandom);
         xv  = $urandom;
         if ($urandom_range(0, 7) == 0) xv = 32'h0;
         dv  = 5'($urandom);
         av  = 1'($urandom);
         xfer(s24, xv, dv, av, $urandom_range(0, 2), $urandom_range(0, 3),
              1'($urandom), zv, sv, lat, held);
         model(s24 ? 24 : 32, xv, int'(dv), av, ze, se);
         n_vec++;
         if (zv !== ze || sv !== se) begin
            n_err++;
            $display("FAIL rnd%0d_result n=%0d x=%h d=%0d a=%b: got %h/%b want %h/%b",
                     i, s24 ? 24 : 32, xv, dv, av, zv, sv, ze, se);
         end
         n_vec++;
         if (lat !== LAT || held !== 1'b1) begin
            n_err++;
            $display("FAIL rnd%0d_timing: got lat=%0d held=%b want %0d/1",
                     i, lat, held, LAT);
         end
      end
   endtask

   initial begin
      drive(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
      drive(1'b1, 1'b0, 32'h0, 5'd0, 1'b0);
      set_ordy(1'b0, 1'b0);
      set_ordy(1'b1, 1'b0);
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
